hazard_controller: RTL and testbench

Pipeline sequencing and hazard controller for the five-stage RISC-V core. It watches the instruction sitting in the decode stage and the destination registers in flight in EX/MEM/WB. From these it drives stall, flush and hold enables for the PC and pipeline registers, forwarding selects for EX, and write-through bypass selects for the decoder's register-file read ports. A small FSM sequences the multi-cycle events: data-memory wait and branch redirect. Two performance counters record stall and flush activity.

---
 rtl/hazard_controller.sv | 178 +++++++++++++++++
 tb/tb_hazard_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller for the five-stage RV32I core.
// Produces stall/flush/hold enables, EX forwarding selects, ID bypass selects and perf counters.
module hazard_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instruction,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_hold,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        id_bypass_1,
  output logic        id_bypass_2,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0] state;
  logic [1:0] resume;
  logic [1:0] next_state;
  logic [1:0] next_resume;
  logic [1:0] eff_state;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [6:0] opcode;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;
  logic       flush_event;
  logic       unused_bits;

  assign id_rs1      = id_instruction[19:15];
  assign id_rs2      = id_instruction[24:20];
  assign opcode      = id_instruction[6:0];
  assign unused_bits = ^{id_instruction[31:25], id_instruction[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_REG, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

  // Leaving HOLD replays the resume state's decision with this cycle's inputs.
  assign eff_state = (state == HOLD && !mem_busy) ? resume : state;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    next_state  = state;
    next_resume = resume;
    flush_event = 1'b0;
    case (eff_state)
      RUN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          next_resume = RUN;
          next_state  = HOLD;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_event = 1'b1;
          next_state  = REDIRECT;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          next_state  = RUN;
        end else begin
          next_state  = RUN;
        end
      end
      REDIRECT: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          next_resume = REDIRECT;
          next_state  = HOLD;
        end else begin
          // Registered instruction memory means this fetch is still wrong-path.
          if_id_flush = 1'b1;
          next_state  = RUN;
        end
      end
      HOLD: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        next_state  = HOLD;
      end
      default: next_state = RUN;
    endcase
    if (!rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_hold   = 1'b0;
      flush_event = 1'b0;
    end
  end

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
      forward_a = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
      forward_a = 2'b01;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
      forward_b = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
      forward_b = 2'b01;
    if (!rst) begin
      forward_a = 2'b00;
      forward_b = 2'b00;
    end
  end

  assign id_bypass_1 = rst && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign id_bypass_2 = rst && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      resume       <= RUN;
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      state  <= next_state;
      resume <= next_resume;
      if (!pc_write)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_event)
        flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller: one linear sequence of cycles with
// hand-computed expectations checked by immediate assertions.
module tb_hazard_controller;

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ADD_X6_5_2 = 32'h00228333;
  localparam logic [31:0] LUI_RS1_5  = 32'h00028337;
  localparam logic [31:0] LUI_RS1_7  = 32'h00038337;
  localparam logic [31:0] LUI_RS1_4  = 32'h00020337;

  logic        clk;
  logic        rst;
  logic [31:0] id_instruction;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_mem_read;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic        branch_taken, mem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
  logic [1:0]  forward_a, forward_b;
  logic        id_bypass_1, id_bypass_2;
  logic [31:0] stall_cycles, flush_count;

  int checks;
  int failures;

  hazard_controller dut (
    .clk            (clk),
    .rst            (rst),
    .id_instruction (id_instruction),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .mem_reg_write  (mem_reg_write),
    .wb_reg_write   (wb_reg_write),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .pipe_hold      (pipe_hold),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .id_bypass_1    (id_bypass_1),
    .id_bypass_2    (id_bypass_2),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so the rising edge sees them settled.
  task applyStimulus(input logic [31:0] instr, input logic mread, input logic [4:0] erd,
                     input logic br, input logic busy);
    @(negedge clk);
    id_instruction = instr;
    ex_mem_read    = mread;
    ex_rd          = erd;
    branch_taken   = br;
    mem_busy       = busy;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    id_instruction = LUI_RS1_4;
    ex_rs1 = 5'd4; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_mem_read = 1'b0;
    mem_rd = 5'd4; wb_rd = 5'd4; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    branch_taken = 1'b0; mem_busy = 1'b0;

    #2;
    checkOutput("rst_pc_write",    32'(pc_write),    32'd0);
    checkOutput("rst_if_id_write", 32'(if_id_write), 32'd0);
    checkOutput("rst_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
    checkOutput("rst_pipe_hold",   32'(pipe_hold),   32'd0);
    checkOutput("rst_forward_a",   32'(forward_a),   32'd0);
    checkOutput("rst_bypass_1",    32'(id_bypass_1), 32'd0);
    checkOutput("rst_stall",       stall_cycles,     32'd0);
    checkOutput("rst_flush_cnt",   flush_count,      32'd0);

    @(negedge clk);
    rst = 1'b1;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;

    // Load-use: lw x5 in EX, add x6,x5,x2 in ID
    applyStimulus(ADD_X6_5_2, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    checkOutput("lu_pc_write",    32'(pc_write),    32'd0);
    checkOutput("lu_if_id_write", 32'(if_id_write), 32'd0);
    checkOutput("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    checkOutput("lu_if_id_flush", 32'(if_id_flush), 32'd0);

    applyStimulus(NOP, 1'b0, 5'd6, 1'b0, 1'b0);
    mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd2;
    #1;
    checkOutput("lu_next_pc_write", 32'(pc_write),  32'd1);
    checkOutput("lu_next_fwd_a",    32'(forward_a), 32'd2);
    checkOutput("lu_next_fwd_b",    32'(forward_b), 32'd0);
    checkOutput("lu_stall_count",   stall_cycles,   32'd1);

    // EX/MEM wins over MEM/WB; ID bypass on matching rs1 field
    applyStimulus(LUI_RS1_7, 1'b0, 5'd6, 1'b0, 1'b0);
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs1 = 5'd3; ex_rs2 = 5'd7;
    #1;
    checkOutput("prio_fwd_b", 32'(forward_b),   32'd2);
    checkOutput("prio_fwd_a", 32'(forward_a),   32'd0);
    checkOutput("bypass_1",   32'(id_bypass_1), 32'd1);
    checkOutput("bypass_2",   32'(id_bypass_2), 32'd0);

    applyStimulus(NOP, 1'b0, 5'd6, 1'b0, 1'b0);
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd0;
    #1;
    checkOutput("x0_fwd_b",    32'(forward_b),   32'd0);
    checkOutput("x0_bypass_1", 32'(id_bypass_1), 32'd0);

    applyStimulus(NOP, 1'b0, 5'd6, 1'b0, 1'b0);
    mem_reg_write = 1'b0; mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7;
    #1;
    checkOutput("wb_fwd_a", 32'(forward_a), 32'd1);

    // lui never reads rs1, so a matching field must not stall
    applyStimulus(LUI_RS1_5, 1'b1, 5'd5, 1'b0, 1'b0);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    #1;
    checkOutput("lui_pc_write",    32'(pc_write),    32'd1);
    checkOutput("lui_id_ex_flush", 32'(id_ex_flush), 32'd0);

    // Branch coinciding with load-use: redirect wins
    applyStimulus(ADD_X6_5_2, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    checkOutput("br_pc_write",    32'(pc_write),    32'd1);
    checkOutput("br_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("br_id_ex_flush", 32'(id_ex_flush), 32'd1);

    applyStimulus(ADD_X6_5_2, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    checkOutput("redir_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("redir_pc_write",    32'(pc_write),    32'd1);
    checkOutput("redir_id_ex_flush", 32'(id_ex_flush), 32'd0);
    checkOutput("redir_flush_cnt",   flush_count,      32'd1);
    checkOutput("redir_stall",       stall_cycles,     32'd1);

    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("post_redir_flush", 32'(if_id_flush), 32'd0);

    // mem_busy for 3 cycles starting in REDIRECT
    applyStimulus(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("br2_if_id_flush", 32'(if_id_flush), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      checkOutput("busy_pipe_hold",   32'(pipe_hold),   32'd1);
      checkOutput("busy_pc_write",    32'(pc_write),    32'd0);
      checkOutput("busy_if_id_flush", 32'(if_id_flush), 32'd0);
    end
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("resume_redir_flush", 32'(if_id_flush), 32'd1);
    checkOutput("resume_redir_pc",    32'(pc_write),    32'd1);
    checkOutput("resume_redir_hold",  32'(pipe_hold),   32'd0);
    checkOutput("busy_stall_count",   stall_cycles,     32'd4);
    checkOutput("busy_flush_count",   flush_count,      32'd2);
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("resume_run_flush", 32'(if_id_flush), 32'd0);

    // Branch held in EX during a memory wait is acted on once afterwards
    applyStimulus(NOP, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("busy_br_flush", 32'(id_ex_flush), 32'd0);
    checkOutput("busy_br_hold",  32'(pipe_hold),   32'd1);
    applyStimulus(NOP, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("hold_br_pc", 32'(pc_write), 32'd0);
    applyStimulus(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("held_br_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("held_br_id_ex_flush", 32'(id_ex_flush), 32'd1);
    checkOutput("held_br_flush_cnt",   flush_count,      32'd2);
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("held_br_redir_flush", 32'(if_id_flush), 32'd1);
    checkOutput("held_br_flush_cnt2",  flush_count,      32'd3);
    checkOutput("held_br_stall",       stall_cycles,     32'd6);

    // Reset while in HOLD
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("pre_rst_hold",  32'(pipe_hold), 32'd1);
    checkOutput("pre_rst_stall", stall_cycles,   32'd7);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_hold",     32'(pipe_hold),   32'd0);
    checkOutput("mid_rst_pc",       32'(pc_write),    32'd0);
    checkOutput("mid_rst_if_flush", 32'(if_id_flush), 32'd1);
    checkOutput("mid_rst_stall",    stall_cycles,     32'd0);
    checkOutput("mid_rst_flush",    flush_count,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_busy = 1'b0;
    applyStimulus(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("post_rst_pc",    32'(pc_write),  32'd1);
    checkOutput("post_rst_hold",  32'(pipe_hold), 32'd0);
    checkOutput("post_rst_stall", stall_cycles,   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
